// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-attached burst RAM: command, error code and arming state.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_SEQ   = 2'b01,
    ERR_RANGE = 2'b10
  } err_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } arm_e;

endpackage

// File: rtl/spi_ram_ptr.sv
// One burst pointer (write or read side): range-checked load, arming FSM and wrapping increment.
//   state | meaning
//   IDLE  | no valid address loaded; data commands are sequence errors
//   ARMED | pointer holds a legal address; each data command uses it and advances
module spi_ram_ptr
  import spi_ram_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [PAYLOAD_W-1:0] addr_i,
  output logic [PAYLOAD_W-1:0] ptr,
  output logic                 armed,
  output logic                 range_err
);

  localparam logic [PAYLOAD_W:0]   DEPTH_C = (PAYLOAD_W+1)'(MEM_DEPTH);
  localparam logic [PAYLOAD_W-1:0] LAST_C  = PAYLOAD_W'(MEM_DEPTH - 1);

  arm_e                 state_q, state_d;
  logic [PAYLOAD_W-1:0] ptr_q, ptr_d;
  logic                 in_range;

  assign in_range = ({1'b0, addr_i} < DEPTH_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (load_i) begin
      state_d = in_range ? ARMED : IDLE;
      if (in_range) ptr_d = addr_i;
    end else if (step_i && state_q == ARMED) begin
      ptr_d = (ptr_q == LAST_C) ? '0 : ptr_q + 1'b1;
    end
  end

  always_comb begin
    armed     = (state_q == ARMED);
    range_err = load_i && !in_range;
    ptr       = ptr_q;
  end

endmodule

// File: rtl/spi_ram_burst.sv
// Burst RAM behind the SPI slave: decodes 2-bit commands into pointer loads, writes and reads,
// and keeps a sticky first-error report.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PAYLOAD_W+1:0] din,
  input  logic                 rx_valid,
  input  logic                 err_clr,
  output logic [PAYLOAD_W-1:0] dout,
  output logic                 tx_valid,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [PAYLOAD_W-1:0] mem [MEM_DEPTH];

  cmd_e                 cmd;
  logic [PAYLOAD_W-1:0] payload;
  logic [PAYLOAD_W-1:0] wr_ptr, rd_ptr;
  logic                 wr_armed, rd_armed, wr_range_err, rd_range_err;
  logic                 wr_step, rd_step, wr_fire, rd_fire, seq_err;
  logic [PAYLOAD_W-1:0] dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;
  err_e                 err_code_q, err_code_d, new_code;

  assign cmd     = cmd_e'(din[PAYLOAD_W+1:PAYLOAD_W]);
  assign payload = din[PAYLOAD_W-1:0];
  assign wr_step = rx_valid && cmd == WR_DATA;
  assign rd_step = rx_valid && cmd == RD_DATA;
  assign wr_fire = wr_step && wr_armed;
  assign rd_fire = rd_step && rd_armed;
  assign seq_err = (wr_step && !wr_armed) || (rd_step && !rd_armed);

  spi_ram_ptr #(.PAYLOAD_W(PAYLOAD_W), .MEM_DEPTH(MEM_DEPTH)) u_wr_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (rx_valid && cmd == WR_ADDR),
    .step_i   (wr_step),
    .addr_i   (payload),
    .ptr      (wr_ptr),
    .armed    (wr_armed),
    .range_err(wr_range_err)
  );

  spi_ram_ptr #(.PAYLOAD_W(PAYLOAD_W), .MEM_DEPTH(MEM_DEPTH)) u_rd_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (rx_valid && cmd == RD_ADDR),
    .step_i   (rd_step),
    .addr_i   (payload),
    .ptr      (rd_ptr),
    .armed    (rd_armed),
    .range_err(rd_range_err)
  );

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= payload;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // A new error beats a simultaneous clear; otherwise the first code is kept.
  always_comb begin
    dout_d     = rd_fire ? mem[rd_ptr[AW-1:0]] : dout_q;
    tx_valid_d = rd_fire;
    new_code   = ERR_NONE;
    if (wr_range_err || rd_range_err) new_code = ERR_RANGE;
    else if (seq_err)                 new_code = ERR_SEQ;
    err_d      = err_q;
    err_code_d = err_code_q;
    if (new_code != ERR_NONE) begin
      if (!err_q || err_clr) begin
        err_d      = 1'b1;
        err_code_d = new_code;
      end
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: a 256-deep and a 200-deep instance share stimulus and are
// each checked every cycle against a behavioural model, plus literal spot checks.
module tb_spi_ram_burst;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0] dout_a, dout_b;
  logic       tx_a, tx_b, err_a, err_b;
  logic [1:0] code_a, code_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_ram_burst #(.PAYLOAD_W(8), .MEM_DEPTH(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .err_clr(err_clr),
    .dout(dout_a), .tx_valid(tx_a), .err(err_a), .err_code(code_a)
  );

  spi_ram_burst #(.PAYLOAD_W(8), .MEM_DEPTH(200)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .err_clr(err_clr),
    .dout(dout_b), .tx_valid(tx_b), .err(err_b), .err_code(code_b)
  );

  // ---------------- behavioural model ----------------
  int         dep [2] = '{256, 200};
  int         wp [2], rp [2];
  bit         wa [2], ra [2];
  logic [7:0] mm [2][256];
  logic [7:0] m_dout [2];
  logic       m_tx [2], m_err [2];
  logic [1:0] m_code [2];

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      wp[i] = 0; rp[i] = 0; wa[i] = 0; ra[i] = 0;
      m_dout[i] = 8'h00; m_tx[i] = 0; m_err[i] = 0; m_code[i] = 2'b00;
    end
  endtask

  task automatic m_step(input int i);
    int         p;
    logic [1:0] e;
    p = int'(din[7:0]);
    e = 2'b00;
    m_tx[i] = 0;
    if (rx_valid) begin
      case (din[9:8])
        2'd0: if (p < dep[i]) begin wp[i] = p; wa[i] = 1; end else begin wa[i] = 0; e = 2'b10; end
        2'd1: if (wa[i]) begin mm[i][wp[i]] = din[7:0]; wp[i] = (wp[i] + 1) % dep[i]; end
              else e = 2'b01;
        2'd2: if (p < dep[i]) begin rp[i] = p; ra[i] = 1; end else begin ra[i] = 0; e = 2'b10; end
        default: if (ra[i]) begin
                   m_dout[i] = mm[i][rp[i]]; m_tx[i] = 1; rp[i] = (rp[i] + 1) % dep[i];
                 end else e = 2'b01;
      endcase
    end
    if (e != 2'b00) begin
      if (!m_err[i] || err_clr) begin m_err[i] = 1; m_code[i] = e; end
    end else if (err_clr) begin
      m_err[i] = 0; m_code[i] = 2'b00;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else for (int i = 0; i < 2; i++) m_step(i);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("a.dout", 32'(dout_a), 32'(m_dout[0]));
      chk("a.tx_valid", 32'(tx_a), 32'(m_tx[0]));
      chk("a.err", 32'(err_a), 32'(m_err[0]));
      chk("a.err_code", 32'(code_a), 32'(m_code[0]));
      chk("b.dout", 32'(dout_b), 32'(m_dout[1]));
      chk("b.tx_valid", 32'(tx_b), 32'(m_tx[1]));
      chk("b.err", 32'(err_b), 32'(m_err[1]));
      chk("b.err_code", 32'(code_b), 32'(m_code[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cmd(input logic [1:0] c, input logic [7:0] p, input logic clr = 1'b0);
    @(negedge clk);
    rx_valid = 1'b1; din = {c, p}; err_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic clr = 1'b0);
    @(negedge clk);
    rx_valid = 1'b0; din = '0; err_clr = clr;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk("rst.dout", 32'(dout_a), 0);
    chk("rst.tx", 32'(tx_a), 0);
    chk("rst.err", 32'(err_a), 0);
    chk("rst.code", 32'(code_b), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // read while unarmed
    cmd(2'd3, 8'h00);
    chk("unarmed_rd.err", 32'(err_a), 1);
    chk("unarmed_rd.code", 32'(code_a), 1);
    chk("unarmed_rd.tx", 32'(tx_a), 0);
    idle(1'b1);
    chk("clr.err", 32'(err_a), 0);

    // write burst wrapping past the top of a 256-word memory
    cmd(2'd0, 8'hFE);
    chk("b.range_fe", 32'(code_b), 2);
    chk("a.no_err_fe", 32'(err_a), 0);
    cmd(2'd1, 8'h11); cmd(2'd1, 8'h22); cmd(2'd1, 8'h33);
    cmd(2'd2, 8'hFE);
    cmd(2'd3, 8'h00); chk("wrap.rd0", 32'({tx_a, dout_a}), 32'h111);
    cmd(2'd3, 8'h00); chk("wrap.rd1", 32'({tx_a, dout_a}), 32'h122);
    cmd(2'd3, 8'h00); chk("wrap.rd2", 32'({tx_a, dout_a}), 32'h133);
    idle(); chk("wrap.tx_drop", 32'(tx_a), 0);
    chk("wrap.dout_hold", 32'(dout_a), 32'h33);
    idle(1'b1);

    // range error on the 200-deep instance, then a write that must be refused
    cmd(2'd0, 8'hC8);
    chk("range.err", 32'(err_b), 1);
    chk("range.code", 32'(code_b), 2);
    cmd(2'd1, 8'h55);
    chk("range.code_kept", 32'(code_b), 2);
    // new SEQ error together with clear: new error wins
    cmd(2'd1, 8'h56, 1'b1);
    chk("collide.err", 32'(err_b), 1);
    chk("collide.code", 32'(code_b), 1);
    chk("collide.a_clear", 32'(err_a), 0);
    idle(1'b1);

    // latency and side independence
    cmd(2'd0, 8'h05); cmd(2'd1, 8'hA5); cmd(2'd2, 8'h05); cmd(2'd3, 8'h00);
    chk("lat.a", 32'({tx_a, dout_a}), 32'h1A5);
    chk("lat.b", 32'({tx_b, dout_b}), 32'h1A5);
    idle(); chk("lat.tx_drop", 32'(tx_a), 0);
    cmd(2'd1, 8'h5A);
    cmd(2'd0, 8'hFF);
    chk("indep.b_range", 32'(code_b), 2);
    cmd(2'd3, 8'h00);
    chk("indep.b_still_armed", 32'({tx_b, dout_b}), 32'h15A);
    chk("indep.a", 32'({tx_a, dout_a}), 32'h15A);
    idle(1'b1);

    // write followed immediately by read of the same address
    cmd(2'd0, 8'h10); cmd(2'd2, 8'h10); cmd(2'd1, 8'h77); cmd(2'd3, 8'h00);
    chk("wtr.a", 32'({tx_a, dout_a}), 32'h177);

    // asynchronous reset mid-burst with outputs non-zero; memory survives
    cmd(2'd1, 8'h00);
    chk("pre_rst.err", 32'(err_b), 0);
    @(negedge clk); rx_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk("mid_rst.dout", 32'(dout_a), 0);
    chk("mid_rst.tx", 32'(tx_a), 0);
    @(negedge clk); rst_n = 1'b1;
    cmd(2'd3, 8'h00);
    chk("post_rst.code", 32'(code_a), 1);
    chk("post_rst.tx", 32'(tx_a), 0);
    cmd(2'd2, 8'h10); cmd(2'd3, 8'h00);
    chk("mem_kept", 32'({tx_a, dout_a}), 32'h177);
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_ram_burst.md
# spi_ram_burst

Parametrised single-port RAM behind the SPI slave. It decodes the 2-bit command carried on each received word and extends the fixed 256×8 RAM with several additions: configurable width and depth, independent write and read pointers that auto-increment for burst transfers, wrap-around at the top of memory, and a sticky protocol-error report. It sits between the SPI slave's receive path (`din`/`rx_valid`) and its transmit path (`dout`/`tx_valid`).

## Interface
- `PAYLOAD_W`, 8: payload width; this is both the data width and the address width.
- `MEM_DEPTH`, 256: number of words. Legal range is 2..2**PAYLOAD_W.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `din` in PAYLOAD_W+2: `din[PAYLOAD_W+1:PAYLOAD_W]` is the command; `din[PAYLOAD_W-1:0]` is the payload.
- `rx_valid` in 1: `din` is valid this cycle; one command per asserted cycle.
- `err_clr` in 1: clears the sticky error.
- `dout` out PAYLOAD_W: read data; holds its last value.
- `tx_valid` out 1: one-cycle pulse marking new `dout`.
- `err` out 1: sticky error flag.
- `err_code` out 2: first error since the last clear. 00 none, 01 SEQ, 10 RANGE.

## Operation
- Commands are acted on only when `rx_valid`=1. When `rx_valid`=0 nothing changes except that `tx_valid` returns to 0.
- 00 WR_ADDR:
  - If payload < `MEM_DEPTH`: `wr_ptr` ← payload and the write side goes ARMED.
  - Otherwise: RANGE error and the write side goes IDLE.
- 01 WR_DATA:
  - If write side is ARMED: `mem[wr_ptr]` ← payload, then `wr_ptr` ← (`wr_ptr`==`MEM_DEPTH`-1) ? 0 : `wr_ptr`+1. The side stays ARMED (burst).
  - If IDLE: SEQ error and no write.
- 10 RD_ADDR: same as WR_ADDR, applied to `rd_ptr` and the read side.
- 11 RD_DATA:
  - If read side is ARMED: `dout` ← `mem[rd_ptr]`, `tx_valid` ← 1, and `rd_ptr` increments with the same wrap rule.
  - If IDLE: SEQ error; `dout` and `tx_valid` are unchanged (`tx_valid` ends up 0).
- Arming:
  - Each side is a two-state FSM, IDLE → ARMED on an in-range address.
  - ARMED → IDLE on an out-of-range address for that side.
  - Reset returns both sides to IDLE.
  - The two sides are independent: a write burst does not disarm the read side.
- Error register:
  - `err` is set on any error.
  - `err_code` records the first error and later errors do not overwrite it.
  - `err_clr` clears both `err` and `err_code` to 0.
  - If `err_clr` and a new error occur in the same cycle, the new error wins: `err`=1 and `err_code` = new code.
- Memory contents are not reset; pointers, FSMs, `dout`, `tx_valid`, `err` and `err_code` are.

## Timing
- Reset values: `dout`=0, `tx_valid`=0, `err`=0, `err_code`=00, both FSMs IDLE, both pointers 0.
- Reset is asynchronous. Asserting `rst_n` mid-burst immediately clears the outputs, and the first edge after release accepts commands normally. Memory contents survive reset.
- Every command takes effect at the edge where it is sampled, so results are visible in the following cycle.
- RD_DATA latency:
  - RD_DATA sampled at edge N gives `tx_valid`=1 and valid `dout` in cycle N+1.
  - `tx_valid` is 0 in cycle N+2 unless another RD_DATA was sampled at edge N+1.
  - Back-to-back RD_DATA holds `tx_valid` high, with new data every cycle.
- Write-then-read: WR_DATA at edge N followed by RD_DATA at edge N+1 to the same address returns the new data (no read-during-write hazard, since only one command is accepted per cycle).
- The error flag updates one cycle after the offending command.

## Structure
- Package `spi_ram_pkg` holds:
  - `cmd_e` (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, 2-bit).
  - `err_e` (ERR_NONE, ERR_SEQ, ERR_RANGE, 2-bit).
  - `arm_e` (IDLE, ARMED).
- Sub-module `spi_ram_ptr`, instantiated twice (write side and read side), contains:
  - the pointer register and arming FSM;
  - the range check on load, parametrised by `PAYLOAD_W` and `MEM_DEPTH`;
  - the wrap-around increment.
- Its outputs are `ptr`, `armed` and `range_err`.
- The top level holds the memory array, the `dout`/`tx_valid` registers and the error register.

## Test plan
- **Reset:** pulse `rst_n` low mid-cycle → `dout`=0, `tx_valid`=0, `err`=0 immediately. After release, RD_DATA → SEQ error, `err_code`=01, `tx_valid` stays 0.
- **Write burst with wrap:** with `MEM_DEPTH`=256, send WR_ADDR 0xFE then WR_DATA 0x11, 0x22, 0x33. Then RD_ADDR 0xFE and three RD_DATA → `dout` = 0x11, 0x22, 0x33 (address 0x00 holds 0x33), `tx_valid` high for three consecutive cycles.
- **Range error:** with `MEM_DEPTH`=200, send WR_ADDR 0xC8 → `err`=1, `err_code`=10. A following WR_DATA 0x55 → no write, `err_code` remains 10.
- **Error clear collision:** hold an existing RANGE error, then assert `err_clr` in the same cycle as an unarmed WR_DATA → `err`=1, `err_code`=01.
- **Latency and independence:** send WR_ADDR 5, WR_DATA 0xA5, RD_ADDR 5, RD_DATA on consecutive cycles → `dout`=0xA5 and `tx_valid`=1 exactly one cycle after RD_DATA, then 0. A further WR_ADDR 0xFF does not disarm the read side.
